dmi_access_ctrl: RTL and testbench

Debug Transport Module side controller for the Debug Module Interface (DMI). It turns the JTAG DTM's single-cycle DR update and capture pulses into a valid/ready `dmi_req_t` transaction toward the debug module, and collects the `dmi_resp_t` answer. It keeps the sticky `dmistat` error state (busy / op-failed) defined by debug spec 0.13. It sits between the DTM TAP logic and the DM CSR block, in the DM clock domain.

---
 rtl/dm_pkg.sv | 52 +++++
 rtl/dmi_access_ctrl.sv | 112 +++++++++++
 tb/tb_dmi_access_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared debug-module types: DMI request/response channel formats, DTM
// operation codes, the sticky dmistat error codes and the DMI access FSM states.
package dm;

   // DTM operation field carried in the DMI data register.
   typedef enum logic [1:0] {
      DTM_NOP   = 2'h0,
      DTM_READ  = 2'h1,
      DTM_WRITE = 2'h2
   } dtm_op_e;

   // Response code reported by the debug module for a successful access.
   localparam logic [1:0] DTM_SUCCESS = 2'h0;

   // Request toward the debug module (41 bits).
   typedef struct packed {
      logic [6:0]  addr;
      dtm_op_e     op;
      logic [31:0] data;
   } dmi_req_t;

   // Response from the debug module (34 bits).
   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } dmi_resp_t;

   // Sticky dmistat error state.
   typedef enum logic [1:0] {
      DMINoError       = 2'h0,
      DMIReservedError = 2'h1,
      DMIOPFailed      = 2'h2,
      DMIBusy          = 2'h3
   } dmi_error_e;

   // DMI access controller states.
   typedef enum logic [2:0] {
      Idle,
      Read,
      WaitRead,
      Write,
      WaitWrite
   } dmi_acc_state_e;

   // Value loaded into the DMI data register on capture (41 bits).
   typedef struct packed {
      logic [6:0]  addr;
      logic [31:0] data;
      dmi_error_e  dmistat;
   } dtm_capture_t;

endpackage

// File: rtl/dmi_access_ctrl.sv
// DMI access controller: turns DTM update/capture pulses into a valid/ready
// request toward the debug module, collects the response, and keeps the sticky
// dmistat error (busy / op-failed) seen by the debugger.
module dmi_access_ctrl
   import dm::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         dtm_update_i,
   input  dmi_req_t     dtm_req_i,
   input  logic         dtm_capture_i,
   output dtm_capture_t dtm_capture_o,
   input  logic         dmireset_i,
   input  logic         dmihardreset_i,
   output dmi_error_e   dmistat_o,
   output logic         dmi_req_valid_o,
   input  logic         dmi_req_ready_i,
   output dmi_req_t     dmi_req_o,
   input  logic         dmi_resp_valid_i,
   output logic         dmi_resp_ready_o,
   input  dmi_resp_t    dmi_resp_i,
   output logic         busy_o
);

   dmi_acc_state_e state_q, state_d;
   dmi_req_t       req_q;
   logic [31:0]    data_q;
   dmi_error_e     error_q;

   logic in_idle;
   logic in_wait;
   logic resp_fire;
   logic update_ok;
   logic set_busy;
   logic set_fail;

   assign in_idle   = (state_q == Idle);
   assign in_wait   = (state_q == WaitRead) || (state_q == WaitWrite);
   assign resp_fire = in_wait && dmi_resp_valid_i;

   // An update only starts work from Idle with a clean error; it is judged
   // against the error held before this edge, so a coincident dmireset does
   // not let it through.
   assign update_ok = in_idle && dtm_update_i && (error_q == DMINoError);

   // Any DR access while a transaction is in flight flags busy.
   assign set_busy  = !in_idle && (dtm_update_i || dtm_capture_i)
                      && (error_q == DMINoError);
   assign set_fail  = resp_fire && (dmi_resp_i.resp != DTM_SUCCESS)
                      && (error_q == DMINoError);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_ni) state_q <= Idle;
      else         state_q <= state_d;
   end

   // Next-state logic and request-valid decode.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_d         = state_q;
      dmi_req_valid_o = 1'b0;
      case (state_q)
         Idle: begin
            if (update_ok) begin
               if (dtm_req_i.op == DTM_READ)       state_d = Read;
               else if (dtm_req_i.op == DTM_WRITE) state_d = Write;
            end
         end
         Read: begin
            dmi_req_valid_o = 1'b1;
            if (dmi_req_ready_i) state_d = WaitRead;
         end
         Write: begin
            dmi_req_valid_o = 1'b1;
            if (dmi_req_ready_i) state_d = WaitWrite;
         end
         WaitRead, WaitWrite: begin
            if (dmi_resp_valid_i) state_d = Idle;
         end
         default: state_d = Idle;
      endcase
      // Hardreset abandons whatever is in flight.
      if (dmihardreset_i) state_d = Idle;
   end

   // Request/response data and the sticky error.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q   <= '0;
         data_q  <= '0;
         error_q <= DMINoError;
      end else begin
         if (update_ok && !dmihardreset_i) req_q  <= dtm_req_i;
         if (resp_fire && !dmihardreset_i) data_q <= dmi_resp_i.data;
         // Hardreset clears; a set from NoError beats a coincident dmireset;
         // busy is reported in preference to op-failed when both land together.
         if (dmihardreset_i)  error_q <= DMINoError;
         else if (set_busy)   error_q <= DMIBusy;
         else if (set_fail)   error_q <= DMIOPFailed;
         else if (dmireset_i) error_q <= DMINoError;
      end
   end

   assign dmi_req_o        = req_q;
   assign dmi_resp_ready_o = 1'b1;
   assign busy_o           = !in_idle;
   assign dmistat_o        = error_q;
   assign dtm_capture_o    = '{addr: req_q.addr, data: data_q, dmistat: error_q};

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Testbench for dmi_access_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a transaction-level
// model of the DMI access rules.
module tb_dmi_access_ctrl;
   import dm::*;

   logic         clk_i;
   logic         rst_ni;
   logic         dtm_update_i;
   dmi_req_t     dtm_req_i;
   logic         dtm_capture_i;
   dtm_capture_t dtm_capture_o;
   logic         dmireset_i;
   logic         dmihardreset_i;
   dmi_error_e   dmistat_o;
   logic         dmi_req_valid_o;
   logic         dmi_req_ready_i;
   dmi_req_t     dmi_req_o;
   logic         dmi_resp_valid_i;
   logic         dmi_resp_ready_o;
   dmi_resp_t    dmi_resp_i;
   logic         busy_o;

   dmi_access_ctrl dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .dtm_update_i     (dtm_update_i),
      .dtm_req_i        (dtm_req_i),
      .dtm_capture_i    (dtm_capture_i),
      .dtm_capture_o    (dtm_capture_o),
      .dmireset_i       (dmireset_i),
      .dmihardreset_i   (dmihardreset_i),
      .dmistat_o        (dmistat_o),
      .dmi_req_valid_o  (dmi_req_valid_o),
      .dmi_req_ready_i  (dmi_req_ready_i),
      .dmi_req_o        (dmi_req_o),
      .dmi_resp_valid_i (dmi_resp_valid_i),
      .dmi_resp_ready_o (dmi_resp_ready_o),
      .dmi_resp_i       (dmi_resp_i),
      .busy_o           (busy_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int n_cmp  = 0;
   int n_fail = 0;
   int hs_count = 0;
   logic cmp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic dmi_req_t mk_req(input logic [6:0] a, input logic [1:0] o, input logic [31:0] d);
      dmi_req_t r;
      r.addr = a;
      r.op   = dtm_op_e'(o);
      r.data = d;
      return r;
   endfunction

   function automatic logic [63:0] cap(input logic [6:0] a, input logic [31:0] d, input logic [1:0] e);
      return 64'({a, d, e});
   endfunction

   // Transaction-level model: a request is either waiting for its handshake,
   // waiting for its answer, or there is none; the error follows the
   // set-from-clean / clear rules.
   logic        m_pend;
   logic        m_wait;
   dmi_req_t    m_req;
   logic [31:0] m_data;
   logic [1:0]  m_err;

   always @(posedge clk_i or negedge rst_ni) begin : model
      logic       in_flight;
      logic [1:0] e_n;
      if (!rst_ni) begin
         m_pend = 1'b0;
         m_wait = 1'b0;
         m_req  = '0;
         m_data = '0;
         m_err  = 2'd0;
      end else if (dmihardreset_i) begin
         m_pend = 1'b0;
         m_wait = 1'b0;
         m_err  = 2'd0;
      end else begin
         in_flight = m_pend || m_wait;
         e_n = m_err;
         if (dmireset_i) e_n = 2'd0;
         if (in_flight && (dtm_update_i || dtm_capture_i) && m_err == 2'd0)
            e_n = 2'd3;
         else if (m_wait && dmi_resp_valid_i && dmi_resp_i.resp != 2'd0 && m_err == 2'd0)
            e_n = 2'd2;
         if (m_wait && dmi_resp_valid_i) begin
            m_data = dmi_resp_i.data;
            m_wait = 1'b0;
         end else if (m_pend && dmi_req_ready_i) begin
            m_pend = 1'b0;
            m_wait = 1'b1;
         end else if (!in_flight && dtm_update_i && m_err == 2'd0) begin
            m_req = dtm_req_i;
            if (dtm_req_i.op == DTM_READ || dtm_req_i.op == DTM_WRITE) m_pend = 1'b1;
         end
         m_err = e_n;
      end
   end

   // Handshake counter on the request channel.
   always @(posedge clk_i) begin
      if (rst_ni && dmi_req_valid_o && dmi_req_ready_i) hs_count++;
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk_i) begin
      if (cmp_en) begin
         check("cmp_req_valid", 64'(dmi_req_valid_o), 64'(m_pend));
         check("cmp_busy", 64'(busy_o), 64'(m_pend || m_wait));
         check("cmp_req", 64'(dmi_req_o), 64'(m_req));
         check("cmp_dmistat", 64'(dmistat_o), 64'(m_err));
         check("cmp_capture", 64'(dtm_capture_o), cap(m_req.addr, m_data, m_err));
         check("cmp_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
      dtm_update_i     = 1'b0;
      dtm_capture_i    = 1'b0;
      dmireset_i       = 1'b0;
      dmihardreset_i   = 1'b0;
      dmi_resp_valid_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},      64'(dmi_req_valid_o),  64'd0);
      check({tag, "_busy"},       64'(busy_o),           64'd0);
      check({tag, "_dmistat"},    64'(dmistat_o),        64'd0);
      check({tag, "_capture"},    64'(dtm_capture_o),    64'd0);
      check({tag, "_req"},        64'(dmi_req_o),        64'd0);
      check({tag, "_resp_ready"}, 64'(dmi_resp_ready_o), 64'd1);
   endtask

   initial begin
      int hs0;
      logic last_pulse;
      logic [63:0] rnd;
      int r;

      rst_ni           = 1'b0;
      dtm_update_i     = 1'b0;
      dtm_req_i        = '0;
      dtm_capture_i    = 1'b0;
      dmireset_i       = 1'b0;
      dmihardreset_i   = 1'b0;
      dmi_req_ready_i  = 1'b0;
      dmi_resp_valid_i = 1'b0;
      dmi_resp_i       = '0;

      repeat (3) @(posedge clk_i);
      #1;
      check_reset_outputs("reset");
      rst_ni = 1'b1;
      cmp_en = 1'b1;

      // Read with zero-wait ready and response.
      tick();
      dmi_req_ready_i = 1'b1;
      dtm_req_i = mk_req(7'h11, 2'h1, 32'h0);
      dtm_update_i = 1'b1;
      tick();
      check("t1_valid_c1", 64'(dmi_req_valid_o), 64'd1);
      check("t1_req", 64'(dmi_req_o), 64'(mk_req(7'h11, 2'h1, 32'h0)));
      tick();
      check("t1_valid_c2", 64'(dmi_req_valid_o), 64'd0);
      dmi_resp_valid_i = 1'b1;
      dmi_resp_i = '{data: 32'h00400382, resp: 2'h0};
      tick();
      check("t1_idle", 64'(busy_o), 64'd0);
      dtm_capture_i = 1'b1;
      tick();
      check("t1_capture", 64'(dtm_capture_o), cap(7'h11, 32'h00400382, 2'h0));

      // Write with ready stalled for five cycles.
      tick();
      dmi_req_ready_i = 1'b0;
      dtm_req_i = mk_req(7'h04, 2'h2, 32'hDEADBEEF);
      dtm_update_i = 1'b1;
      hs0 = hs_count;
      tick();
      for (int i = 0; i < 6; i++) begin
         check("t2_valid_held", 64'(dmi_req_valid_o), 64'd1);
         check("t2_req_stable", 64'(dmi_req_o), 64'(mk_req(7'h04, 2'h2, 32'hDEADBEEF)));
         if (i == 5) dmi_req_ready_i = 1'b1;
         tick();
      end
      check("t2_valid_after", 64'(dmi_req_valid_o), 64'd0);
      check("t2_busy_wait", 64'(busy_o), 64'd1);
      check("t2_one_handshake", 64'(hs_count - hs0), 64'd1);
      dmi_resp_valid_i = 1'b1;
      dmi_resp_i = '{data: 32'h0BADF00D, resp: 2'h0};
      tick();
      check("t2_idle", 64'(busy_o), 64'd0);
      check("t2_capture", 64'(dtm_capture_o), cap(7'h04, 32'h0BADF00D, 2'h0));

      // Busy error: update during WaitRead.
      tick();
      dtm_req_i = mk_req(7'h22, 2'h1, 32'h0);
      dtm_update_i = 1'b1;
      tick();
      tick();
      check("t3_in_wait", 64'(busy_o), 64'd1);
      dtm_req_i = mk_req(7'h7F, 2'h2, 32'hFFFFFFFF);
      dtm_update_i = 1'b1;
      tick();
      check("t3_stat_busy", 64'(dmistat_o), 64'd3);
      check("t3_no_new_req", 64'(dmi_req_valid_o), 64'd0);
      dmi_resp_valid_i = 1'b1;
      dmi_resp_i = '{data: 32'hCAFE0001, resp: 2'h0};
      tick();
      check("t3_read_done", 64'(dtm_capture_o), cap(7'h22, 32'hCAFE0001, 2'h3));
      dtm_capture_i = 1'b1;
      tick();
      check("t3_capture_low", 64'(dtm_capture_o.dmistat), 64'd3);
      tick();
      dtm_req_i = mk_req(7'h33, 2'h1, 32'h0);
      dtm_update_i = 1'b1;
      tick();
      check("t3_ignored_valid", 64'(dmi_req_valid_o), 64'd0);
      check("t3_ignored_busy", 64'(busy_o), 64'd0);
      tick();
      dtm_update_i = 1'b1;
      dmireset_i = 1'b1;
      tick();
      check("t3_reset_upd_ignored", 64'(dmi_req_valid_o), 64'd0);
      check("t3_stat_cleared", 64'(dmistat_o), 64'd0);
      tick();
      dtm_update_i = 1'b1;
      tick();
      check("t3_reissue_valid", 64'(dmi_req_valid_o), 64'd1);
      check("t3_reissue_req", 64'(dmi_req_o), 64'(mk_req(7'h33, 2'h1, 32'h0)));
      tick();
      dmi_resp_valid_i = 1'b1;
      dmi_resp_i = '{data: 32'h00000001, resp: 2'h0};
      tick();

      // Op failed, then sticky against later activity.
      tick();
      dtm_req_i = mk_req(7'h05, 2'h1, 32'h0);
      dtm_update_i = 1'b1;
      tick();
      tick();
      dmi_resp_valid_i = 1'b1;
      dmi_resp_i = '{data: 32'hAAAA5555, resp: 2'h2};
      tick();
      check("t4_stat_failed", 64'(dmistat_o), 64'd2);
      check("t4_capture", 64'(dtm_capture_o), cap(7'h05, 32'hAAAA5555, 2'h2));
      tick();
      dtm_req_i = mk_req(7'h06, 2'h1, 32'h0);
      dtm_update_i = 1'b1;
      tick();
      check("t4_upd_ignored", 64'(dmi_req_valid_o), 64'd0);
      check("t4_stat_sticky", 64'(dmistat_o), 64'd2);
      tick();
      dtm_capture_i = 1'b1;
      tick();
      check("t4_stat_after_cap", 64'(dmistat_o), 64'd2);
      dmireset_i = 1'b1;
      tick();
      check("t4_stat_cleared", 64'(dmistat_o), 64'd0);
      // dmireset coinciding with a busy-setting capture: the set wins.
      dmi_req_ready_i = 1'b0;
      tick();
      dtm_req_i = mk_req(7'h07, 2'h1, 32'h0);
      dtm_update_i = 1'b1;
      tick();
      tick();
      dtm_capture_i = 1'b1;
      dmireset_i = 1'b1;
      tick();
      check("t4_set_wins", 64'(dmistat_o), 64'd3);
      check("t4_valid_kept", 64'(dmi_req_valid_o), 64'd1);

      // Hardreset mid-Read with ready low.
      dmihardreset_i = 1'b1;
      tick();
      check("t5_valid_drop", 64'(dmi_req_valid_o), 64'd0);
      check("t5_idle", 64'(busy_o), 64'd0);
      check("t5_stat_clear", 64'(dmistat_o), 64'd0);
      dmi_resp_valid_i = 1'b1;
      dmi_resp_i = '{data: 32'h99999999, resp: 2'h3};
      tick();
      check("t5_late_resp_dropped", 64'(dtm_capture_o), cap(7'h07, 32'hAAAA5555, 2'h0));
      dmi_req_ready_i = 1'b1;

      // Asynchronous reset during WaitWrite.
      tick();
      dtm_req_i = mk_req(7'h55, 2'h2, 32'h01020304);
      dtm_update_i = 1'b1;
      tick();
      tick();
      check("t6_in_waitwrite", 64'(busy_o), 64'd1);
      #1;
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("t6_async");
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // Randomized traffic against the model.
      last_pulse = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 7));
         if (!last_pulse && r == 0) begin
            rnd = {$urandom(), $urandom()};
            dtm_req_i = rnd[40:0];
            dtm_update_i = 1'b1;
         end else if (!last_pulse && r == 1) begin
            dtm_capture_i = 1'b1;
         end
         last_pulse = dtm_update_i || dtm_capture_i;
         dmireset_i       = ($urandom_range(0, 15) == 0);
         dmihardreset_i   = ($urandom_range(0, 63) == 0);
         dmi_req_ready_i  = ($urandom_range(0, 1) == 1);
         dmi_resp_valid_i = ($urandom_range(0, 2) == 0);
         r = int'($urandom_range(0, 7));
         dmi_resp_i.data = $urandom();
         dmi_resp_i.resp = (r == 6) ? 2'h2 : (r == 7) ? 2'h3 : 2'h0;
         tick();
      end

      tick();
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
